// File: rtl/des_perm_pipe.sv
// rtl/des_perm_pipe.sv - DES IP/FP permutation register plus output FIFO; optional macro DES_PERM_IDENT_EN
module des_perm_pipe #(
    parameter int LANES = 1,
    parameter int DEPTH = 4
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst_n,
    input  logic                      i_Valid,
    output logic                      o_Ready,
    input  logic [1:0]                i_Mode,
    input  logic [64*LANES-1:0]       i_Data,
    output logic                      o_Valid,
    input  logic                      i_Ready,
    output logic [1:0]                o_Mode,
    output logic [64*LANES-1:0]       o_Data,
    output logic [$clog2(DEPTH):0]    o_Level,
    output logic                      o_Err
);

    localparam int W     = 64 * LANES;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam int OCC_W = LW + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    // Permutation networks: pure wiring, one copy per lane.
    logic [W-1:0] ip_data;
    logic [W-1:0] fp_data;
    logic [W-1:0] perm_data;
    logic         mode_rsvd;

    // IP output bit i+1 (FIPS numbering) takes input bit s; FP is the inverse map.
    // Row r of the IP table starts at 58,60,62,64,57,59,61,63 and steps down by 8.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar i = 0; i < 64; i++) begin : g_bit
            localparam int R = i / 8;
            localparam int C = i % 8;
            localparam int S = ((R < 4) ? (58 + 2 * R) : (57 + 2 * (R - 4))) - 8 * C;
            assign ip_data[64*l + 63 - i] = i_Data[64*l + 64 - S];
            assign fp_data[64*l + 64 - S] = i_Data[64*l + 63 - i];
        end
    end

    // Mode select and reserved-mode decode for the incoming beat.
    always_comb begin
        perm_data = i_Data;
        case (i_Mode)
            2'b00:   perm_data = ip_data;
            2'b01:   perm_data = fp_data;
            default: perm_data = i_Data;
        endcase
`ifdef DES_PERM_IDENT_EN
        mode_rsvd = (i_Mode == 2'b11);
`else
        mode_rsvd = i_Mode[1];
`endif
    end

    // State
    logic            s1_valid_q, s1_valid_d;
    logic [W-1:0]    s1_data_q,  s1_data_d;
    logic [1:0]      s1_mode_q,  s1_mode_d;
    logic [W-1:0]    mem_data_q [DEPTH];
    logic [W-1:0]    mem_data_d [DEPTH];
    logic [1:0]      mem_mode_q [DEPTH];
    logic [1:0]      mem_mode_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   count_q,  count_d;
    logic            err_q,    err_d;

    logic [OCC_W-1:0] occ;
    logic             pop;
    logic             push;
    logic             accept;

    // Handshake: readiness counts the beat sitting in stage 1 so it can always drain.
    always_comb begin
        occ     = OCC_W'(count_q) + OCC_W'(s1_valid_q);
        pop     = (count_q != '0) && i_Ready;
        push    = s1_valid_q;
        o_Ready = i_Rst_n && ((occ < DEPTH_OCC) || ((occ == DEPTH_OCC) && pop));
        accept  = i_Valid && o_Ready;
    end

    // Next-state: stage-1 capture, FIFO write/read, occupancy and sticky error.
    always_comb begin
        s1_valid_d = accept;
        s1_data_d  = s1_data_q;
        s1_mode_d  = s1_mode_q;
        mem_data_d = mem_data_q;
        mem_mode_d = mem_mode_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + LW'(push) - LW'(pop);
        err_d      = err_q | (accept & mode_rsvd);
        if (accept) begin
            s1_data_d = perm_data;
            s1_mode_d = i_Mode;
        end
        if (push) begin
            mem_data_d[wr_ptr_q] = s1_data_q;
            mem_mode_d[wr_ptr_q] = s1_mode_q;
            wr_ptr_d             = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    // Control and stage-1 registers with synchronous reset.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= 2'b00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_mode_q  <= s1_mode_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

    // FIFO storage; contents are don't-care while empty because outputs are gated.
    always_ff @(posedge i_Clk) begin
        mem_data_q <= mem_data_d;
        mem_mode_q <= mem_mode_d;
    end

    // Output view of the FIFO head.
    always_comb begin
        o_Valid = (count_q != '0);
        o_Data  = o_Valid ? mem_data_q[rd_ptr_q] : '0;
        o_Mode  = o_Valid ? mem_mode_q[rd_ptr_q] : 2'b00;
        o_Level = count_q;
        o_Err   = err_q;
    end

endmodule

// File: tb/tb_des_perm_pipe.sv
// tb/tb_des_perm_pipe.sv - randomized scoreboard bench for des_perm_pipe (LANES=2, DEPTH=4)
module tb_des_perm_pipe;

    localparam int LANES = 2;
    localparam int DEPTH = 4;
    localparam int W     = 64 * LANES;

    logic            clk = 1'b0;
    logic            i_Rst_n = 1'b0;
    logic            i_Valid = 1'b0;
    logic            o_Ready;
    logic [1:0]      i_Mode = 2'b00;
    logic [W-1:0]    i_Data = '0;
    logic            o_Valid;
    logic            i_Ready = 1'b0;
    logic [1:0]      o_Mode;
    logic [W-1:0]    o_Data;
    logic [2:0]      o_Level;
    logic            o_Err;

    des_perm_pipe #(.LANES(LANES), .DEPTH(DEPTH)) dut (
        .i_Clk   (clk),
        .i_Rst_n (i_Rst_n),
        .i_Valid (i_Valid),
        .o_Ready (o_Ready),
        .i_Mode  (i_Mode),
        .i_Data  (i_Data),
        .o_Valid (o_Valid),
        .i_Ready (i_Ready),
        .o_Mode  (o_Mode),
        .o_Data  (o_Data),
        .o_Level (o_Level),
        .o_Err   (o_Err)
    );

    always #5 clk = ~clk;

    int ip_t [64] = '{58,50,42,34,26,18,10, 2,60,52,44,36,28,20,12, 4,
                      62,54,46,38,30,22,14, 6,64,56,48,40,32,24,16, 8,
                      57,49,41,33,25,17, 9, 1,59,51,43,35,27,19,11, 3,
                      61,53,45,37,29,21,13, 5,63,55,47,39,31,23,15, 7};
    int fp_t [64] = '{40, 8,48,16,56,24,64,32,39, 7,47,15,55,23,63,31,
                      38, 6,46,14,54,22,62,30,37, 5,45,13,53,21,61,29,
                      36, 4,44,12,52,20,60,28,35, 3,43,11,51,19,59,27,
                      34, 2,42,10,50,18,58,26,33, 1,41, 9,49,17,57,25};

    typedef struct {
        logic [W-1:0] d;
        logic [1:0]   m;
        int           acc;
    } beat_t;

    beat_t q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    logic  err_m = 1'b0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [63:0] perm64(input logic [63:0] x, input logic [1:0] m);
        logic [63:0] y;
        y = x;
        if (m == 2'b00) for (int n = 1; n <= 64; n++) y[64-n] = x[64-ip_t[n-1]];
        if (m == 2'b01) for (int n = 1; n <= 64; n++) y[64-n] = x[64-fp_t[n-1]];
        return y;
    endfunction

    function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [1:0] m);
        logic [W-1:0] y;
        for (int l = 0; l < LANES; l++) y[64*l +: 64] = perm64(x[64*l +: 64], m);
        return y;
    endfunction

    function automatic logic rsvd(input logic [1:0] m);
`ifdef DES_PERM_IDENT_EN
        return m == 2'b11;
`else
        return m[1];
`endif
    endfunction

    // One clock cycle: drive inputs, compare every output with the model, update the model.
    task automatic step(input logic v, input logic [1:0] m, input logic [W-1:0] d, input logic r);
        int  vis;
        int  occ;
        logic pop_m;
        logic rdy_m;
        beat_t b;
        @(posedge clk);
        cyc++;
        #1;
        i_Valid = v;
        i_Mode  = m;
        i_Data  = d;
        i_Ready = r;
        #1;
        vis = 0;
        foreach (q[k]) if (q[k].acc <= cyc - 2) vis++;
        occ   = q.size();
        pop_m = (vis != 0) && r;
        rdy_m = (occ < DEPTH) || ((occ == DEPTH) && pop_m);
        check("level", W'(o_Level), W'(vis));
        check("valid", W'(o_Valid), W'(vis != 0));
        check("ready", W'(o_Ready), W'(rdy_m));
        check("err",   W'(o_Err),   W'(err_m));
        if (o_Valid && r) begin
            if (q.size() == 0) begin
                check("spurious_pop", W'(1), W'(0));
            end else begin
                b = q.pop_front();
                check("data", o_Data, b.d);
                check("mode", W'(o_Mode), W'(b.m));
            end
        end
        if (v && o_Ready) begin
            b.d = model(d, m);
            b.m = m;
            b.acc = cyc;
            q.push_back(b);
            if (rsvd(m)) err_m = 1'b1;
        end
    endtask

    task automatic idle_drain();
        for (int k = 0; k < 20 && q.size() != 0; k++) step(1'b0, 2'b00, '0, 1'b1);
        check("drain_empty", W'(q.size()), W'(0));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        i_Rst_n = 1'b0;
        i_Valid = 1'b0;
        i_Ready = 1'b0;
        #1;
        check("rst_ready_low", W'(o_Ready), W'(0));
        @(posedge clk);
        #1;
        check("rst_valid", W'(o_Valid), W'(0));
        check("rst_level", W'(o_Level), W'(0));
        check("rst_err",   W'(o_Err),   W'(0));
        check("rst_data",  o_Data,      W'(0));
        check("rst_mode",  W'(o_Mode),  W'(0));
        check("rst_ready", W'(o_Ready), W'(0));
        i_Rst_n = 1'b1;
        q.delete();
        err_m = 1'b0;
        #1;
        check("ready_after_rst", W'(o_Ready), W'(1));
    endtask

    initial begin
        logic [63:0] one;
        logic [1:0]  rm;

        do_reset();

        // Known-answer vectors for the reference model itself.
        check("kat_ip",   W'(perm64(64'h0123456789ABCDEF, 2'b00)), W'(64'hCC00CCFFF0AAF0AA));
        check("kat_fp",   W'(perm64(64'hCC00CCFFF0AAF0AA, 2'b01)), W'(64'h0123456789ABCDEF));
        check("kat_bit",  W'(perm64(64'h40, 2'b00)),              W'(64'h8000000000000000));

        // Known-answer beats through the DUT, lane1 = 0 then lane1 carries the vector.
        step(1'b1, 2'b00, {64'h0, 64'h0123456789ABCDEF}, 1'b1);
        step(1'b1, 2'b01, {64'h0, 64'hCC00CCFFF0AAF0AA}, 1'b1);
        step(1'b1, 2'b00, {64'h0123456789ABCDEF, 64'h40}, 1'b1);
        idle_drain();

        // Single-bit walk: FP of each one-hot, then IP of that result.
        for (int b = 0; b < 64; b++) begin
            one = 64'h1 << b;
            step(1'b1, 2'b01, {one, ~one}, 1'b1);
            step(1'b1, 2'b00, {perm64(one, 2'b01), perm64(~one, 2'b01)}, 1'b1);
            check("walk_roundtrip", W'(perm64(perm64(one, 2'b01), 2'b00)), W'(one));
        end
        idle_drain();

        // Backpressure fill, then resume with continuous streaming.
        for (int k = 0; k < 8; k++) step(1'b1, 2'b00, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        check("fill_level", W'(o_Level), W'(DEPTH));
        check("fill_ready", W'(o_Ready), W'(0));
        for (int k = 0; k < 6; k++) step(1'b1, 2'b01, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        idle_drain();

        // Randomized traffic with all modes and random backpressure.
        for (int k = 0; k < 400; k++) begin
            rm = ($urandom_range(0, 9) < 8) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            step($urandom_range(0, 3) != 0, rm, {$urandom, $urandom, $urandom, $urandom},
                 $urandom_range(0, 3) != 0);
        end
        idle_drain();

        // Reset with three beats queued, then latency of the first new beat.
        for (int k = 0; k < 3; k++) step(1'b1, 2'b11, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        step(1'b0, 2'b00, '0, 1'b0);
        do_reset();
        step(1'b1, 2'b00, {64'h0, 64'h0123456789ABCDEF}, 1'b1);
        step(1'b0, 2'b00, '0, 1'b1);
        step(1'b0, 2'b00, '0, 1'b1);
        idle_drain();

        // Mode 2'b10 then 2'b11 error behaviour.
        step(1'b1, 2'b10, {64'hDEADBEEF00000000, 64'h0123456789ABCDEF}, 1'b1);
        step(1'b0, 2'b00, '0, 1'b1);
`ifdef DES_PERM_IDENT_EN
        check("err_mode10", W'(o_Err), W'(0));
`else
        check("err_mode10", W'(o_Err), W'(1));
`endif
        step(1'b1, 2'b11, {64'h0, 64'h5555AAAA5555AAAA}, 1'b1);
        step(1'b0, 2'b00, '0, 1'b1);
        check("err_mode11", W'(o_Err), W'(1));
        step(1'b1, 2'b00, {64'h0, 64'h1}, 1'b1);
        idle_drain();
        check("err_sticky", W'(o_Err), W'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
